// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS controller FSM; define MCC_PERF_CNT_EN for CycleCount/InstrCount
module multi_cycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SignExtend,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
`endif
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, IEXEC = 4'd10, IWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
    OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
    OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111,
    OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111, ALU_XOR = 4'b1010, ALU_SLTU = 4'b1011, ALU_LUI = 4'b1110, ALU_FUNC = 4'b1111;
  state_t state, next_state;
  assign State = state;
  // state register; reset lands in FETCH immediately
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= FETCH;
    else state <= next_state;
  // control decode and next-state; write/strobe enables are squashed while Reset is high
  always_comb begin
    next_state = FETCH;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemToReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    SignExtend = 1'b0;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    ALUOp = ALU_ADD;
    IllegalOp = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        SignExtend = 1'b1;
        case (Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R: next_state = EXEC;
          OP_BEQ: next_state = BRANCH;
          OP_J: next_state = JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: next_state = IEXEC;
          default: IllegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        SignExtend = 1'b1;
        next_state = (Opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        next_state = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        next_state = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_FUNC;
        next_state = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        SignExtend = Opcode inside {OP_ADDI, OP_SLTI, OP_SLTIU};
        ALUOp = (Opcode == OP_ORI) ? ALU_OR :
                (Opcode == OP_ANDI) ? ALU_AND :
                (Opcode == OP_LUI) ? ALU_LUI :
                (Opcode == OP_SLTI) ? ALU_SLT :
                (Opcode == OP_SLTIU) ? ALU_SLTU :
                (Opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        next_state = IWB;
      end
      IWB: RegWrite = 1'b1;
      default: next_state = FETCH;
    endcase
    if (Reset) begin
      PCWrite = 1'b0;
      PCWriteCond = 1'b0;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      IRWrite = 1'b0;
      RegWrite = 1'b0;
      IllegalOp = 1'b0;
    end
  end
`ifdef MCC_PERF_CNT_EN
  logic retire;
  assign retire = (state inside {MEMWB, RWB, BRANCH, JUMP, IWB}) || (state == MEMWR && MemReady);
  // free-running cycle counter and retired-instruction counter (illegal returns excluded)
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      CycleCount <= CycleCount + 32'd1;
      if (retire) InstrCount <= InstrCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench for the multi-cycle controller
module tb_multi_cycle_control;
  logic CLK = 1'b0, Reset = 1'b1, MemReady = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite;
  logic ALUSrcA, SignExtend, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;
`ifdef MCC_PERF_CNT_EN
  logic [31:0] CycleCount, InstrCount, cc0, ic0;
`endif
  int total = 0, bad = 0;
  localparam logic [11:0] ILL = 12'h001, SE = 12'h002, SA = 12'h004, RW = 12'h008, RD = 12'h010,
    M2R = 12'h020, IRW = 12'h040, MW = 12'h080, MR = 12'h100, IORD = 12'h200, PCC = 12'h400,
    PCW = 12'h800;
  typedef struct {string nm; logic [23:0] v;} exp_t;
  exp_t q[$];
  multi_cycle_control dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SignExtend(SignExtend), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
`ifdef MCC_PERF_CNT_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic step(input bit r, input logic [5:0] op, input bit rdy, input string nm,
                      input logic [3:0] st, input logic [3:0] alu, input logic [1:0] pcs,
                      input logic [1:0] sb, input logic [11:0] fl);
    @(posedge CLK);
    #1;
    Reset = r;
    Opcode = op;
    MemReady = rdy;
    q.push_back('{nm, {st, alu, pcs, sb, fl}});
  endtask
  // monitor: every falling edge compares the full control word against the oldest expectation
  initial forever begin
    logic [23:0] got;
    exp_t e;
    @(negedge CLK);
    if (q.size() != 0) begin
      e = q.pop_front();
      got = {State, ALUOp, PCSource, ALUSrcB, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
             IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, SignExtend, IllegalOp};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.nm, got, e.v);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    step(1, 6'h00, 1, "reset", 4'd0, 4'h2, 2'd0, 2'd1, 12'h000);
    step(0, 6'h00, 1, "r_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h00, 1, "r_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h00, 1, "r_exec", 4'd6, 4'hF, 2'd0, 2'd0, SA);
    step(0, 6'h00, 1, "r_rwb", 4'd7, 4'h2, 2'd0, 2'd0, RW | RD);
    step(0, 6'h23, 1, "lw_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h23, 1, "lw_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h23, 0, "lw_memadr", 4'd2, 4'h2, 2'd0, 2'd2, SA | SE);
    step(0, 6'h23, 0, "lw_memrd_w1", 4'd3, 4'h2, 2'd0, 2'd0, MR | IORD);
    step(0, 6'h23, 0, "lw_memrd_w2", 4'd3, 4'h2, 2'd0, 2'd0, MR | IORD);
    step(0, 6'h23, 1, "lw_memrd_rdy", 4'd3, 4'h2, 2'd0, 2'd0, MR | IORD);
    step(0, 6'h23, 1, "lw_memwb", 4'd4, 4'h2, 2'd0, 2'd0, RW | M2R);
    step(0, 6'h04, 1, "beq_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h04, 1, "beq_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h04, 1, "beq_branch", 4'd8, 4'h6, 2'd1, 2'd0, SA | PCC);
    step(0, 6'h0A, 1, "slti_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h0A, 1, "slti_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h0A, 1, "slti_iexec", 4'd10, 4'h7, 2'd0, 2'd2, SA | SE);
    step(0, 6'h0A, 1, "slti_iwb", 4'd11, 4'h2, 2'd0, 2'd0, RW);
    step(0, 6'h0C, 1, "andi_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h0C, 1, "andi_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h0C, 1, "andi_iexec", 4'd10, 4'h0, 2'd0, 2'd2, SA);
    step(0, 6'h0C, 1, "andi_iwb", 4'd11, 4'h2, 2'd0, 2'd0, RW);
    step(0, 6'h0F, 1, "lui_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h0F, 1, "lui_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h0F, 1, "lui_iexec", 4'd10, 4'hE, 2'd0, 2'd2, SA);
    step(0, 6'h0F, 1, "lui_iwb", 4'd11, 4'h2, 2'd0, 2'd0, RW);
    step(0, 6'h3F, 1, "ill_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
`ifdef MCC_PERF_CNT_EN
    cc0 = CycleCount;
    ic0 = InstrCount;
`endif
    step(0, 6'h3F, 1, "ill_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE | ILL);
    step(0, 6'h02, 0, "j_fetch_wait", 4'd0, 4'h2, 2'd0, 2'd1, MR);
`ifdef MCC_PERF_CNT_EN
    total += 2;
    if (CycleCount !== cc0 + 32'd2) begin
      bad++;
      $display("FAIL ill_cycles: got %0d expected %0d", CycleCount, cc0 + 32'd2);
    end
    if (InstrCount !== ic0) begin
      bad++;
      $display("FAIL ill_instrs: got %0d expected %0d", InstrCount, ic0);
    end
`endif
    step(0, 6'h02, 1, "j_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h02, 1, "j_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h02, 1, "j_jump", 4'd9, 4'h2, 2'd2, 2'd0, PCW);
    step(0, 6'h2B, 1, "sw_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h2B, 1, "sw_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h2B, 1, "sw_memadr", 4'd2, 4'h2, 2'd0, 2'd2, SA | SE);
    step(0, 6'h2B, 1, "sw_memwr", 4'd5, 4'h2, 2'd0, 2'd0, MW | IORD);
    step(0, 6'h2B, 1, "sw2_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h2B, 1, "sw2_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    step(0, 6'h2B, 0, "sw2_memadr", 4'd2, 4'h2, 2'd0, 2'd2, SA | SE);
    step(0, 6'h2B, 0, "sw2_memwr_w1", 4'd5, 4'h2, 2'd0, 2'd0, MW | IORD);
    step(0, 6'h2B, 0, "sw2_memwr_w2", 4'd5, 4'h2, 2'd0, 2'd0, MW | IORD);
    step(1, 6'h2B, 0, "abort_reset", 4'd0, 4'h2, 2'd0, 2'd1, 12'h000);
    step(0, 6'h00, 1, "post_reset_fetch", 4'd0, 4'h2, 2'd0, 2'd1, MR | IRW | PCW);
    step(0, 6'h00, 1, "post_reset_decode", 4'd1, 4'h2, 2'd0, 2'd3, SE);
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
